// File: rtl/fifo_pkg.sv
// Shared definitions for the burst framer: hold-slot FSM encoding, counter
// widths and the beat-index width helper.
// The burst_framer top honours the build macro BURST_FRAMER_STATS_EN.
package fifo_pkg;

    // Hold-slot state: EMPTY = H empty, PEND = H holds a beat with last
    // unresolved, CLOSE = H must leave with last=1.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PEND  = 2'd1,
        CLOSE = 2'd2
    } state_t;

    // Width of the optional completed-burst counter.
    localparam int STATS_W = 16;

    // Width of the idle counter; TIMEOUT never exceeds 255.
    localparam int TIMER_W = 8;

    // Bits needed to hold a beat index 0..burst-1.
    function automatic int idx_width(input int burst);
        if (burst > 2) begin
            return $clog2(burst);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/burst_timer.sv
// Idle counter for the burst framer. Counts while enabled, saturates at
// TIMEOUT, clears on request; expired is high while the count sits at TIMEOUT.
module burst_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

    logic [TIMER_W-1:0] count_r;

    // Idle count: clear wins over increment, and the count holds at LIMIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (clear) begin
            count_r <= {TIMER_W{1'b0}};
        end else if (inc && (count_r != LIMIT)) begin
            count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LIMIT);

endmodule

// File: rtl/burst_framer.sv
// Burst framer: re-times a valid/ready beat stream through a hold slot H and
// an output slot O, marking the final beat of each burst with last_o. A burst
// closes after BURST beats or after TIMEOUT idle cycles with a beat held.
// Build option: define BURST_FRAMER_STATS_EN to add the 16-bit bursts_o
// counter of completed (last_o=1) downstream transfers.
module burst_framer
    import fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int BURST   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
`ifdef BURST_FRAMER_STATS_EN
    ,
    output logic [STATS_W-1:0] bursts_o
`endif
);

    localparam int               IDX_W    = idx_width(BURST);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t           state_r;
    logic [WIDTH-1:0] h_data_r;
    logic [IDX_W-1:0] h_idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic             o_free_s;
    logic             up_xfer_s;
    logic             h_empties_s;
    logic             timer_inc_s;
    logic             timer_clear_s;
    logic             expired_s;

    // O can take a new beat when it is empty or being drained this cycle.
    assign o_free_s   = !valid_o || ready_i;
    // Never looks at valid_i, so upstream may wait on ready_o safely.
    assign ready_o    = (state_r == EMPTY) || o_free_s;
    assign up_xfer_s  = valid_i && ready_o;
    assign idx_next_s = h_idx_r + IDX_ONE;

    // Detect H draining with nothing arriving to replace it.
    always_comb begin
        h_empties_s = 1'b0;
        case (state_r)
            PEND:    h_empties_s = !up_xfer_s && expired_s && o_free_s;
            CLOSE:   h_empties_s = !up_xfer_s && o_free_s;
            default: h_empties_s = 1'b0;
        endcase
    end

    assign timer_inc_s   = (state_r != EMPTY);
    assign timer_clear_s = up_xfer_s || h_empties_s;

    burst_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .inc     (timer_inc_s),
        .clear   (timer_clear_s),
        .expired (expired_s)
    );

    // Hold/output slot FSM. An upstream transfer always beats a timeout, so
    // a held beat pushed out by a new arrival leaves with last_o=0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= EMPTY;
            h_data_r <= {WIDTH{1'b0}};
            h_idx_r  <= {IDX_W{1'b0}};
            valid_o  <= 1'b0;
            last_o   <= 1'b0;
            data_o   <= {WIDTH{1'b0}};
        end else begin
            if (o_free_s) begin
                valid_o <= 1'b0;
            end
            case (state_r)
                EMPTY: begin
                    // The index is always 0 here and BURST >= 2, so the new
                    // beat can never be the closing one.
                    if (up_xfer_s) begin
                        h_data_r <= data_i;
                        state_r  <= PEND;
                    end
                end
                PEND: begin
                    if (up_xfer_s) begin
                        data_o   <= h_data_r;
                        last_o   <= 1'b0;
                        valid_o  <= 1'b1;
                        h_data_r <= data_i;
                        h_idx_r  <= idx_next_s;
                        state_r  <= (idx_next_s == IDX_LAST) ? CLOSE : PEND;
                    end else if (expired_s && o_free_s) begin
                        data_o   <= h_data_r;
                        last_o   <= 1'b1;
                        valid_o  <= 1'b1;
                        h_idx_r  <= {IDX_W{1'b0}};
                        state_r  <= EMPTY;
                    end
                end
                CLOSE: begin
                    if (o_free_s) begin
                        data_o   <= h_data_r;
                        last_o   <= 1'b1;
                        valid_o  <= 1'b1;
                        h_idx_r  <= {IDX_W{1'b0}};
                        if (up_xfer_s) begin
                            h_data_r <= data_i;
                            state_r  <= PEND;
                        end else begin
                            state_r  <= EMPTY;
                        end
                    end
                end
                default: begin
                    state_r <= EMPTY;
                    h_idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

`ifdef BURST_FRAMER_STATS_EN
    // Completed-burst counter; wraps from 65535 back to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            bursts_o <= {STATS_W{1'b0}};
        end else if (valid_o && ready_i && last_o) begin
            bursts_o <= bursts_o + {{(STATS_W-1){1'b0}}, 1'b1};
        end else begin
            bursts_o <= bursts_o;
        end
    end
`endif

endmodule

// File: tb/tb_burst_framer.sv
// Directed self-checking bench for burst_framer (WIDTH=8, BURST=4, TIMEOUT=8).
// Define BURST_FRAMER_STATS_EN to also cover the bursts_o counter.
module tb_burst_framer;

    logic       clock;
    logic       reset;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;
    logic       last_o;
`ifdef BURST_FRAMER_STATS_EN
    logic [15:0] bursts_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Downstream transfers captured at the falling edge before they happen.
    logic [7:0] cap_data [0:255];
    logic       cap_last [0:255];
    int         cap_n = 0;

    burst_framer #(
        .WIDTH   (8),
        .BURST   (4),
        .TIMEOUT (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o)
`ifdef BURST_FRAMER_STATS_EN
        ,
        .bursts_o (bursts_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every downstream handshake outside reset.
    always @(negedge clock) begin
        if (!reset && valid_o && ready_i && cap_n < 256) begin
            cap_data[cap_n] <= data_o;
            cap_last[cap_n] <= last_o;
            cap_n           <= cap_n + 1;
        end
    end

    task automatic test_reset();
        reset   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid_o: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (last_o !== 1'b0) $display("FAIL reset_last_o: got %b want 0", last_o); else n_pass++;
        n_checks++; if (data_o !== 8'h00) $display("FAIL reset_data_o: got %h want 00", data_o); else n_pass++;
`ifdef BURST_FRAMER_STATS_EN
        n_checks++; if (bursts_o !== 16'd0) $display("FAIL reset_bursts_o: got %0d want 0", bursts_o); else n_pass++;
`endif
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready_o: got %b want 1", ready_o); else n_pass++;
    endtask

    task automatic test_stream();
        int base;
        base    = cap_n;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = 8'(i);
            #1;
            n_checks++; if (ready_o !== 1'b1) $display("FAIL stream_ready_o[%0d]: got %b want 1", i, ready_o); else n_pass++;
            @(posedge clock);
            #1;
        end
        valid_i = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        n_checks++; if (cap_n - base !== 8) $display("FAIL stream_count: got %0d want 8", cap_n - base); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (cap_data[base+i] !== 8'(i)) $display("FAIL stream_data[%0d]: got %h want %h", i, cap_data[base+i], 8'(i)); else n_pass++;
            n_checks++; if (cap_last[base+i] !== ((i == 3) || (i == 7))) $display("FAIL stream_last[%0d]: got %b want %b", i, cap_last[base+i], ((i == 3) || (i == 7))); else n_pass++;
        end
`ifdef BURST_FRAMER_STATS_EN
        n_checks++; if (bursts_o !== 16'd2) $display("FAIL stream_bursts_o: got %0d want 2", bursts_o); else n_pass++;
`endif
    endtask

    task automatic test_timeout();
        int base;
        int lat;
        base    = cap_n;
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'hA5;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        lat = 0;
        while (valid_o !== 1'b1 && lat < 30) begin
            @(posedge clock);
            #1;
            lat++;
        end
        n_checks++; if (lat !== 9) $display("FAIL timeout_latency: got %0d want 9", lat); else n_pass++;
        n_checks++; if (data_o !== 8'hA5) $display("FAIL timeout_data: got %h want a5", data_o); else n_pass++;
        n_checks++; if (last_o !== 1'b1) $display("FAIL timeout_last: got %b want 1", last_o); else n_pass++;
        @(posedge clock);
        #1;
        n_checks++; if (cap_n - base !== 1) $display("FAIL timeout_count: got %0d want 1", cap_n - base); else n_pass++;
    endtask

    task automatic test_backpressure();
        int base;
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 8'h10;
        @(posedge clock);
        #1;
        data_i  = 8'h11;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        n_checks++; if (ready_o !== 1'b0) $display("FAIL bp_ready_o: got %b want 0", ready_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b1) $display("FAIL bp_valid_o: got %b want 1", valid_o); else n_pass++;
        n_checks++; if (data_o !== 8'h10) $display("FAIL bp_data_o: got %h want 10", data_o); else n_pass++;
        n_checks++; if (last_o !== 1'b0) $display("FAIL bp_last_o: got %b want 0", last_o); else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (data_o !== 8'h10) $display("FAIL bp_hold_data: got %h want 10", data_o); else n_pass++;
        n_checks++; if (last_o !== 1'b0) $display("FAIL bp_hold_last: got %b want 0", last_o); else n_pass++;
        base    = cap_n;
        ready_i = 1'b1;
        repeat (15) @(posedge clock);
        #1;
        n_checks++; if (cap_n - base !== 2) $display("FAIL bp_count: got %0d want 2", cap_n - base); else n_pass++;
        n_checks++; if (cap_data[base] !== 8'h10) $display("FAIL bp_first_data: got %h want 10", cap_data[base]); else n_pass++;
        n_checks++; if (cap_last[base] !== 1'b0) $display("FAIL bp_first_last: got %b want 0", cap_last[base]); else n_pass++;
        n_checks++; if (cap_data[base+1] !== 8'h11) $display("FAIL bp_second_data: got %h want 11", cap_data[base+1]); else n_pass++;
        n_checks++; if (cap_last[base+1] !== 1'b1) $display("FAIL bp_second_last: got %b want 1", cap_last[base+1]); else n_pass++;
    endtask

    task automatic test_collision();
        int base;
        base    = cap_n;
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h30;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        valid_i = 1'b1;
        data_i  = 8'h31;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL coll_ready_o: got %b want 1", ready_o); else n_pass++;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        n_checks++; if (cap_n - base !== 2) $display("FAIL coll_count: got %0d want 2", cap_n - base); else n_pass++;
        n_checks++; if (cap_data[base] !== 8'h30) $display("FAIL coll_first_data: got %h want 30", cap_data[base]); else n_pass++;
        n_checks++; if (cap_last[base] !== 1'b0) $display("FAIL coll_first_last: got %b want 0", cap_last[base]); else n_pass++;
        n_checks++; if (cap_data[base+1] !== 8'h31) $display("FAIL coll_second_data: got %h want 31", cap_data[base+1]); else n_pass++;
        n_checks++; if (cap_last[base+1] !== 1'b1) $display("FAIL coll_second_last: got %b want 1", cap_last[base+1]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h50;
        @(posedge clock);
        #1;
        data_i  = 8'h51;
        @(posedge clock);
        #1;
        valid_i = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        base  = cap_n;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL mid_valid_o: got %b want 0", valid_o); else n_pass++;
        n_checks++; if (ready_o !== 1'b1) $display("FAIL mid_ready_o: got %b want 1", ready_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = 8'h20 + 8'(i);
            @(posedge clock);
            #1;
        end
        valid_i = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        n_checks++; if (cap_n - base !== 4) $display("FAIL mid_count: got %0d want 4", cap_n - base); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (cap_data[base+i] !== 8'h20 + 8'(i)) $display("FAIL mid_data[%0d]: got %h want %h", i, cap_data[base+i], 8'h20 + 8'(i)); else n_pass++;
            n_checks++; if (cap_last[base+i] !== (i == 3)) $display("FAIL mid_last[%0d]: got %b want %b", i, cap_last[base+i], (i == 3)); else n_pass++;
        end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b1;
        test_reset();
        test_stream();
        test_timeout();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/burst_framer.md
BURST_FRAMER -- requirements
Module: burst_framer

Interface
- REQ-001: Parameter WIDTH, default 8, data beat width in bits.
- REQ-002: Parameter BURST, default 8, maximum beats per burst, range 2..256.
- REQ-003: Parameter TIMEOUT, default 16, idle cycles before a partial burst closes, range 1..255.
- REQ-004: clock  input  1  sole clock; all state updates on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: valid_i  input  1  upstream beat valid; this port is driven by sync_fifo valid_o.
- REQ-007: ready_o  output  1  upstream beat accept.
- REQ-008: data_i  input  WIDTH  upstream beat data.
- REQ-009: valid_o  output  1  downstream beat valid.
- REQ-010: ready_i  input  1  downstream beat accept.
- REQ-011: data_o  output  WIDTH  downstream beat data.
- REQ-012: last_o  output  1  final beat of burst, qualified by valid_o.

Function
- REQ-013: A transfer on either side shall occur only on a cycle with valid and ready both high.
- REQ-014: The block shall hold two registers: hold slot H (data, valid, beat index) and output slot O (data_o, last_o, valid_o).
- REQ-015: The FSM shall have state EMPTY when H is empty, PEND when H holds a beat with last unresolved, and CLOSE when H must exit with last=1.
- REQ-016: O is free when valid_o=0 or ready_i=1.
- REQ-017: ready_o shall be high when H is empty, or when O is free; it shall depend combinationally only on registered state and ready_i, never on valid_i.
- REQ-018: The accepted beat enters H in every case: in EMPTY directly; in PEND, H moves to O with last_o=0 in the same cycle.
- REQ-019: H shall move to O with last_o=1 once O is free, if H's beat index equals BURST-1, or if the idle counter has reached TIMEOUT.
- REQ-020: The beat index shall increment per beat leaving H; it shall reset to 0 after a last_o=1 beat leaves H.
- REQ-021: The idle counter shall count cycles with H valid and no upstream transfer, saturate at TIMEOUT, and clear on any upstream transfer or when H empties.
- REQ-022: Latency shall be one cycle from acceptance to valid_o for a beat closing the burst at index BURST-1.
- REQ-023: Latency for other beats shall be until the next accept or until TIMEOUT+1 cycles.
- REQ-024: O shall hold data_o and last_o stable while valid_o=1 and ready_i=0.
- REQ-025: Simultaneous timeout expiry and upstream transfer: the transfer shall win, and the held beat shall exit with last_o=0.
- REQ-026: Beat order shall be preserved; no beat shall be dropped or duplicated.

Reset
- REQ-027: On reset, valid_o=0, last_o=0, data_o=0, H empty, beat index=0, idle counter=0, and state EMPTY.
- REQ-028: ready_o shall be 1 in the first cycle after reset deasserts.
- REQ-029: Reset mid-burst shall discard H and O contents, and the next accepted beat shall be index 0.

Configuration
- REQ-030: With macro BURST_FRAMER_STATS_EN defined, the block shall add output port bursts_o (16 bits), counting last_o=1 downstream transfers and wrapping at 65535 to 0.
- REQ-031: bursts_o shall reset to 0.
- REQ-032: Without BURST_FRAMER_STATS_EN, port bursts_o and its counter shall not exist, and all other behaviour shall be identical.

Structure
- REQ-033: Package fifo_pkg shall hold the FSM state encoding (EMPTY, PEND, CLOSE) and the stats counter width constant.
- REQ-034: One sub-module burst_timer (idle counter with clear, saturate, and expired flag) is natural.
- REQ-035: All other logic shall stay in burst_framer.

Verification (WIDTH=8, BURST=4, TIMEOUT=8)
- REQ-036: Continuous input 0x00..0x07 with ready_i=1 shall produce outputs 0x00..0x07, with last_o=1 on 0x03 and 0x07 only.
- REQ-037: Single beat 0xA5 then idle shall produce valid_o on 0xA5 with last_o=1 exactly 9 cycles after its acceptance.
- REQ-038: Beats 0x10, 0x11 with ready_i=0 shall give ready_o=0 after the second beat is accepted, with O=0x10, last_o=0, stable; releasing ready_i shall then give 0x10, 0x11 in order.
- REQ-039: A beat arriving on the same cycle the idle counter reaches 8 shall cause the held beat to exit with last_o=0.
- REQ-040: Reset asserted after 2 of 4 beats, then 0x20..0x23 sent, shall produce last_o on 0x23 only.
- REQ-041: With BURST_FRAMER_STATS_EN, after the REQ-036 stimulus bursts_o shall equal 2.
